// File: rtl/he_hssi_f_rx_pkt_checker.sv
// RX packet checker for the F-tile traffic controller. It counts packets and bytes
// and flags length, MAC and tkeep errors behind a two-stage pipeline.
package ofs_fim_eth_plat_if_pkg;
  localparam int ETH_PACKET_WIDTH = 512;
endpackage

module he_hssi_f_rx_pkt_checker #(
  parameter int DATA_WIDTH  = ofs_fim_eth_plat_if_pkg::ETH_PACKET_WIDTH,
  parameter int NO_OF_BYTES = DATA_WIDTH / 8,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_tvalid,
  output logic                   rx_tready,
  input  logic [DATA_WIDTH-1:0]  rx_tdata,
  input  logic [NO_OF_BYTES-1:0] rx_tkeep,
  input  logic                   rx_tlast,
  input  logic                   rx_tuser_err,
  input  logic [15:0]            cfg_exp_len,
  input  logic                   clear_stats,
  output logic [CNT_WIDTH-1:0]   pkt_cnt,
  output logic [CNT_WIDTH-1:0]   byte_cnt,
  output logic [CNT_WIDTH-1:0]   mac_err_cnt,
  output logic [CNT_WIDTH-1:0]   len_err_cnt,
  output logic [CNT_WIDTH-1:0]   keep_err_cnt,
  output logic [15:0]            last_pkt_len,
  output logic                   in_pkt
);

  localparam int PW = $clog2(NO_OF_BYTES + 1);
  localparam int SW = ((CNT_WIDTH > 16) ? CNT_WIDTH : 16) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t state, state_nxt;

  // Payload is never inspected; the bus exists only for width compatibility.
  wire unused_tdata = ^rx_tdata;

  function automatic logic [PW-1:0] popcount(input logic [NO_OF_BYTES-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NO_OF_BYTES; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [15:0]          inc);
    logic [SW-1:0] sum;
    sum = SW'(cnt) + SW'(inc);
    return (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  endfunction

  logic                   accept;
  logic [NO_OF_BYTES-1:0] keep_inc;
  logic                   keep_bad;

  assign accept   = rx_tvalid && rx_tready;
  assign keep_inc = rx_tkeep + NO_OF_BYTES'(1);
  assign in_pkt   = (state == IN_PKT);

  // A last beat must be a non-empty contiguous run from byte 0; other beats must be full.
  always_comb begin
    if (rx_tlast) keep_bad = (rx_tkeep == '0) || ((rx_tkeep & keep_inc) != '0);
    else          keep_bad = (rx_tkeep != '1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_tready <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_tready <= 1'b1;
    end
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !rx_tlast) state_nxt = IN_PKT;
      IN_PKT:  if (accept &&  rx_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic          s1_valid, s1_sop, s1_eop, s1_drop, s1_mac_err, s1_keep_bad;
  logic [PW-1:0] s1_bytes;
  logic [15:0]   s1_exp_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sop      <= 1'b0;
      s1_eop      <= 1'b0;
      s1_drop     <= 1'b0;
      s1_mac_err  <= 1'b0;
      s1_keep_bad <= 1'b0;
      s1_bytes    <= '0;
      s1_exp_len  <= '0;
    end else begin
      s1_valid    <= accept;
      s1_sop      <= (state == IDLE);
      s1_eop      <= rx_tlast;
      s1_drop     <= clear_stats;  // an EOP arriving with a clear is discarded next stage
      s1_mac_err  <= rx_tuser_err && rx_tlast;
      s1_keep_bad <= keep_bad;
      s1_bytes    <= popcount(rx_tkeep);
      s1_exp_len  <= cfg_exp_len;
    end
  end

  logic [15:0] len_acc;
  logic        keep_flag;
  logic [16:0] len_sum;
  logic [15:0] len_now;
  logic        keep_now, count_en, len_mismatch;

  assign len_sum      = {1'b0, len_acc} + 17'(s1_bytes);
  assign len_now      = s1_sop ? 16'(s1_bytes) : (len_sum[16] ? 16'hFFFF : len_sum[15:0]);
  assign keep_now     = s1_keep_bad || (!s1_sop && keep_flag);
  assign count_en     = s1_valid && s1_eop && !s1_drop;
  assign len_mismatch = (s1_exp_len != 16'd0) && (len_now != s1_exp_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_acc      <= '0;
      keep_flag    <= 1'b0;
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      mac_err_cnt  <= '0;
      len_err_cnt  <= '0;
      keep_err_cnt <= '0;
      last_pkt_len <= '0;
    end else begin
      if (s1_valid) begin
        len_acc   <= len_now;
        keep_flag <= keep_now;
      end
      if (clear_stats) begin
        pkt_cnt      <= '0;
        byte_cnt     <= '0;
        mac_err_cnt  <= '0;
        len_err_cnt  <= '0;
        keep_err_cnt <= '0;
        last_pkt_len <= '0;
      end else if (count_en) begin
        pkt_cnt      <= sat_add(pkt_cnt, 16'd1);
        byte_cnt     <= sat_add(byte_cnt, len_now);
        mac_err_cnt  <= sat_add(mac_err_cnt, {15'd0, s1_mac_err});
        len_err_cnt  <= sat_add(len_err_cnt, {15'd0, len_mismatch});
        keep_err_cnt <= sat_add(keep_err_cnt, {15'd0, keep_now});
        last_pkt_len <= len_now;
      end
    end
  end

endmodule
